// File: rtl/decodifica_hamming_pkg.sv
// Hamming(15,11) code layout shared by encoder, syndrome logic and decoder.
// Bit i of a codeword is code position i+1.
package decodifica_hamming_pkg;

   localparam int unsigned N = 15;
   localparam int unsigned K = 11;

   localparam logic [3:0] POS_PARIDADE [4] = '{4'd0, 4'd1, 4'd3, 4'd7};
   localparam logic [3:0] POS_DADOS [K] =
      '{4'd2, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14};

   typedef struct packed {
      logic [N-1:0] palavra;
      logic [3:0]   sindrome;
   } estagio1_t;

   function automatic logic [K-1:0] extrai_dados(input logic [N-1:0] c);
      logic [K-1:0] d;
      d = '0;
      for (int unsigned j = 0; j < K; j++)
         d[j] = c[POS_DADOS[j]];
      return d;
   endfunction

   // Parity bit k covers every position whose index+1 has bit k set.
   function automatic logic [N-1:0] codifica(input logic [K-1:0] d);
      logic [N-1:0] c;
      logic         p;
      c = '0;
      for (int unsigned j = 0; j < K; j++)
         c[POS_DADOS[j]] = d[j];
      for (int unsigned k = 0; k < 4; k++) begin
         p = 1'b0;
         for (int unsigned i = 0; i < N; i++)
            if ((((i + 1) >> k) & 1) != 0)
               p = p ^ c[i];
         c[POS_PARIDADE[k]] = p;
      end
      return c;
   endfunction

endpackage

// File: rtl/decodifica_hamming_sindrome.sv
// Combinational Hamming(15,11) syndrome: XOR of the positions of all set bits,
// which equals {s8,s4,s2,s1}.
module sindrome_hamming
   import decodifica_hamming_pkg::*;
(
   input  logic [N-1:0] palavra,
   output logic [3:0]   sindrome
);

   always_comb begin
      sindrome = '0;
      for (int unsigned i = 0; i < N; i++)
         if (palavra[i])
            sindrome = sindrome ^ 4'(i + 1);
   end

endmodule

// File: rtl/decodifica_hamming.sv
// Two-stage Hamming(15,11) single-error-correcting decoder with valid/ready
// handshakes and a saturating count of corrected words delivered.
module decodifica_hamming
   import decodifica_hamming_pkg::*;
#(
   parameter int unsigned CONT_W = 16
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              entrada_valid,
   output logic              entrada_pronto,
   input  logic [N-1:0]      entrada,
   output logic              saida_valid,
   input  logic              saida_pronto,
   output logic [K-1:0]      saida,
   output logic [3:0]        sindrome,
   output logic              corrigido,
   input  logic              limpa_cont,
   output logic [CONT_W-1:0] cont_corrigidos
);

   logic [3:0]   sindrome_entrada;
   estagio1_t    est1;
   logic         est1_valid;
   logic [N-1:0] palavra_corrigida;
   logic         avanca1;
   logic         avanca2;

   sindrome_hamming u_sindrome (
      .palavra  (entrada),
      .sindrome (sindrome_entrada)
   );

   assign avanca2        = !saida_valid || saida_pronto;
   assign avanca1        = !est1_valid || avanca2;
   assign entrada_pronto = avanca1;

   // Flip the bit addressed by the syndrome; a zero syndrome matches no bit.
   always_comb begin
      palavra_corrigida = '0;
      for (int unsigned i = 0; i < N; i++)
         palavra_corrigida[i] = est1.palavra[i] ^ (est1.sindrome == 4'(i + 1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         est1_valid      <= 1'b0;
         est1            <= '0;
         saida_valid     <= 1'b0;
         saida           <= '0;
         sindrome        <= '0;
         corrigido       <= 1'b0;
         cont_corrigidos <= '0;
      end else begin
         if (avanca1) begin
            est1_valid <= entrada_valid;
            if (entrada_valid)
               est1 <= '{palavra: entrada, sindrome: sindrome_entrada};
         end

         if (avanca2) begin
            saida_valid <= est1_valid;
            if (est1_valid) begin
               saida     <= extrai_dados(palavra_corrigida);
               sindrome  <= est1.sindrome;
               corrigido <= (est1.sindrome != '0);
            end
         end

         if (limpa_cont)
            cont_corrigidos <= '0;
         else if (saida_valid && saida_pronto && corrigido && (cont_corrigidos != '1))
            cont_corrigidos <= cont_corrigidos + CONT_W'(1);
      end
   end

endmodule

// File: doc/decodifica_hamming.md
DECODIFICA_HAMMING -- requirements
Module: decodifica_hamming

Interface
REQ-001 Parameter: CONT_W, 16, width of the corrected-word counter.
REQ-002 Port: clk  in  1  single clock; all state SHALL update on rising edge.
REQ-003 Port: rst  in  1  synchronous, active-high reset.
REQ-004 Port: entrada_valid  in  1  input codeword valid.
REQ-005 Port: entrada_pronto  out  1  block accepts input this cycle.
REQ-006 Port: entrada  in  15  Hamming(15,11) codeword, bit i = code position i+1.
REQ-007 Port: saida_valid  out  1  decoded word valid.
REQ-008 Port: saida_pronto  in  1  downstream accepts output this cycle.
REQ-009 Port: saida  out  11  corrected data word.
REQ-010 Port: sindrome  out  4  syndrome of the word on saida, {s8,s4,s2,s1}.
REQ-011 Port: corrigido  out  1  the word on saida had a nonzero syndrome.
REQ-012 Port: limpa_cont  in  1  synchronous clear of cont_corrigidos.
REQ-013 Port: cont_corrigidos  out  CONT_W  count of delivered words with nonzero syndrome.

Function
REQ-014 Code layout SHALL be: bits 0,1,3,7 = p1,p2,p4,p8; data d0..d10 at bits 2,4,5,6,8,9,10,11,12,13,14.
REQ-015 s_k SHALL be the XOR of all entrada bits whose position (index+1) has bit k set, k in {0,1,2,3}.
REQ-016 Nonzero syndrome S SHALL invert codeword bit S-1 before data extraction; S=0 leaves the word unchanged.
REQ-017 Parity-bit errors (S = 1,2,4,8) SHALL yield unchanged data with corrigido=1.
REQ-018 Double errors are undetectable; the block SHALL apply the single-error rule regardless.
REQ-019 Two-stage pipeline: stage 1 registers codeword + syndrome; stage 2 registers saida, sindrome, corrigido.
REQ-020 Input handshake occurs when entrada_valid && entrada_pronto; output handshake when saida_valid && saida_pronto.
REQ-021 Unstalled latency SHALL be 2 cycles from input handshake to saida_valid; throughput 1 word/cycle.
REQ-022 Stage 2 advances when !saida_valid || saida_pronto; stage 1 advances when empty or stage 2 advances; entrada_pronto = stage-1-advance.
REQ-023 While saida_valid && !saida_pronto, saida, sindrome, corrigido SHALL hold stable.
REQ-024 No word SHALL be dropped or duplicated under any valid/pronto pattern.
REQ-025 cont_corrigidos SHALL increment by 1 on each output handshake with corrigido=1.
REQ-026 cont_corrigidos SHALL saturate at 2^CONT_W-1.
REQ-027 limpa_cont SHALL set the counter to 0 next cycle; clear wins over a simultaneous increment.

Reset
REQ-028 rst SHALL clear both stage valids, saida, sindrome, corrigido and cont_corrigidos to 0.
REQ-029 rst mid-operation SHALL discard all in-flight words; entrada_pronto SHALL be 1 the cycle after rst deasserts.
REQ-030 Input handshakes in a cycle with rst asserted SHALL be ignored.

Structure
REQ-031 Shared package SHALL hold code constants: N=15, K=11, parity-position list, data-position list.
REQ-032 Syndrome computation SHALL be a combinational sub-module sindrome_hamming (15-bit in, 4-bit out).
REQ-033 Encoder and decoder SHALL use the same package layout so a loopback is bit-exact.

Verification
REQ-034 entrada 15'h0000, saida_pronto=1 -> 2 cycles later saida 11'h000, sindrome 0, corrigido 0, counter 0.
REQ-035 entrada 15'h7FEF (all-ones codeword, bit 4 flipped) -> saida 11'h7FF, sindrome 4'd5, corrigido 1, counter 1.
REQ-036 entrada 15'h0001 (parity p1 flipped) -> saida 11'h000, sindrome 4'd1, corrigido 1.
REQ-037 Stream of 8 words with saida_pronto toggling randomly -> all 8 delivered in order, unchanged while stalled, entrada_pronto=0 once both stages full and stalled.
REQ-038 CONT_W=4, 20 single-error words -> counter stops at 15; limpa_cont coincident with an errored handshake -> counter 0.
REQ-039 rst asserted with 2 words in flight -> saida_valid 0 next cycle, no stale word emitted afterwards.
